ammo_launcher: RTL and testbench

- Player-side bullet pool; the counterpart to the obstacle block's hit-detection interface.
- Spawns bullets above the ship when fire is pressed and moves active bullets upward once per frame.
- Presents one active bullet per frame on the ball_ammo_* bus, round-robin over active slots.
- Retires the presented bullet when the obstacle block returns bullet_hit one frame later, or when it leaves the top of the screen.

---
 rtl/ammo_launcher.sv | 151 +++++++++++++++
 tb/tb_ammo_launcher.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ammo_launcher.sv
// rtl/ammo_launcher.sv - player bullet pool with round-robin hit probe; AMMO_AUTOFIRE_EN enables held-key autofire
module ammo_launcher #(
  parameter int AMMO_NUM   = 4,
  parameter int AMMO_SIZE  = 4,
  parameter int AMMO_SPEED = 6,
  parameter int COOLDOWN   = 8,
  parameter int Y_MIN      = 3,
  parameter int PARK_X     = 700
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] ship_x,
  input  logic [9:0] ship_y,
  input  logic [9:0] ship_size,
  input  logic       fire,
  input  logic       bullet_hit,
  output logic [9:0] ball_ammo_x,
  output logic [9:0] ball_ammo_y,
  output logic [9:0] ball_ammo_size,
  output logic [9:0] ammo_X [AMMO_NUM],
  output logic [9:0] ammo_Y [AMMO_NUM],
  output logic       ammo_active [AMMO_NUM],
  output logic [2:0] ammo_count
);

  localparam int IDX_W = (AMMO_NUM > 1) ? $clog2(AMMO_NUM) : 1;
  localparam int CNT_W = $clog2(COOLDOWN + 1);
  localparam logic [9:0] MOVE_LIM  = 10'(Y_MIN + AMMO_SPEED);
  localparam logic [9:0] SPAWN_LIM = 10'(Y_MIN + AMMO_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_COOLDOWN, S_WAIT_RELEASE} fire_state_t;

  fire_state_t          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     probe_idx_q;
  logic [IDX_W-1:0]     probe_prev_q;
  logic                 probe_valid_q;

  logic [AMMO_NUM-1:0]  act_vec;
  logic [AMMO_NUM-1:0]  kill_vec;
  logic [IDX_W-1:0]     spawn_idx;
  logic [IDX_W-1:0]     probe_idx_d;
  logic [IDX_W-1:0]     cand;
  logic                 spawn_ok;
  logic                 fire_go;
  logic [9:0]           spawn_x;
  logic [9:0]           spawn_y;

  // Decisions for this frame, all taken from the start-of-cycle slot vector
  always_comb begin
    act_vec  = '0;
    kill_vec = '0;
    for (int i = 0; i < AMMO_NUM; i++) act_vec[i] = ammo_active[i];
    if (bullet_hit && probe_valid_q) kill_vec[probe_prev_q] = 1'b1;

    // Descending scan so the lowest free slot wins
    spawn_idx = '0;
    for (int i = AMMO_NUM - 1; i >= 0; i--) begin
      if (!act_vec[i]) spawn_idx = IDX_W'(i);
    end
    spawn_ok = (act_vec != {AMMO_NUM{1'b1}}) && (ship_y >= SPAWN_LIM);
    fire_go  = (state_q == S_IDLE) && fire && spawn_ok;
    spawn_x  = ship_x + (ship_size >> 1) - 10'(AMMO_SIZE >> 1);
    spawn_y  = ship_y - 10'(AMMO_SIZE);

    // Nearest active slot after the probe, cyclically; itself is checked last
    probe_idx_d = probe_idx_q;
    cand        = '0;
    for (int k = AMMO_NUM; k >= 1; k--) begin
      cand = IDX_W'((int'(probe_idx_q) + k) % AMMO_NUM);
      if (act_vec[cand]) probe_idx_d = cand;
    end
  end

  // Presented bullet, parked off-screen when the probed slot is empty
  always_comb begin
    ball_ammo_size = 10'(AMMO_SIZE);
    if (act_vec[probe_idx_q]) begin
      ball_ammo_x = ammo_X[probe_idx_q];
      ball_ammo_y = ammo_Y[probe_idx_q];
    end else begin
      ball_ammo_x = 10'(PARK_X);
      ball_ammo_y = '0;
    end
    ammo_count = '0;
    for (int i = 0; i < AMMO_NUM; i++) ammo_count = ammo_count + 3'(act_vec[i]);
  end

  // Fire FSM: one shot then cooldown; without autofire the key must be released
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fire_go) begin
            cnt_q   <= CNT_W'(COOLDOWN - 1);
            state_q <= S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          if (cnt_q == '0) begin
`ifdef AMMO_AUTOFIRE_EN
            state_q <= S_IDLE;
`else
            state_q <= fire ? S_WAIT_RELEASE : S_IDLE;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WAIT_RELEASE: begin
          if (!fire) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Slot update (hit beats movement, spawn only into slots free at cycle start) and probe advance
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      for (int i = 0; i < AMMO_NUM; i++) begin
        ammo_X[i]      <= '0;
        ammo_Y[i]      <= '0;
        ammo_active[i] <= 1'b0;
      end
      probe_idx_q   <= '0;
      probe_prev_q  <= '0;
      probe_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < AMMO_NUM; i++) begin
        if (kill_vec[i]) begin
          ammo_active[i] <= 1'b0;
        end else if (act_vec[i]) begin
          if (ammo_Y[i] < MOVE_LIM) ammo_active[i] <= 1'b0;
          else                      ammo_Y[i]      <= ammo_Y[i] - 10'(AMMO_SPEED);
        end else if (fire_go && (spawn_idx == IDX_W'(i))) begin
          ammo_X[i]      <= spawn_x;
          ammo_Y[i]      <= spawn_y;
          ammo_active[i] <= 1'b1;
        end
      end
      probe_idx_q   <= probe_idx_d;
      probe_prev_q  <= probe_idx_q;
      probe_valid_q <= act_vec[probe_idx_q];
    end
  end

endmodule

// File: tb/tb_ammo_launcher.sv
// tb/tb_ammo_launcher.sv - table-driven scoreboard bench for ammo_launcher
module tb_ammo_launcher;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [9:0] ship_x, ship_y, ship_size;
  logic       fire, bullet_hit;
  logic [9:0] ball_ammo_x, ball_ammo_y, ball_ammo_size;
  logic [9:0] ammo_X [4];
  logic [9:0] ammo_Y [4];
  logic       ammo_active [4];
  logic [2:0] ammo_count;
  logic [3:0] act_v;

  ammo_launcher dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .ship_x(ship_x), .ship_y(ship_y), .ship_size(ship_size),
    .fire(fire), .bullet_hit(bullet_hit),
    .ball_ammo_x(ball_ammo_x), .ball_ammo_y(ball_ammo_y), .ball_ammo_size(ball_ammo_size),
    .ammo_X(ammo_X), .ammo_Y(ammo_Y), .ammo_active(ammo_active), .ammo_count(ammo_count)
  );

  always #5 frame_clk = ~frame_clk;

  always_comb begin
    act_v = '0;
    for (int i = 0; i < 4; i++) act_v[i] = ammo_active[i];
  end

  typedef struct {
    bit         rst;
    bit         fire;
    bit         hit;
    logic [9:0] sx;
    logic [9:0] sy;
    int         cnt;
    logic [3:0] act;
    bit         chk_b;
    logic [9:0] bx;
    logic [9:0] by;
  } vec_t;

  typedef struct {
    int         row;
    int         cnt;
    logic [3:0] act;
    bit         chk_b;
    logic [9:0] bx;
    logic [9:0] by;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   row_id = 0;

  function automatic vec_t mk(bit rst, bit f, bit h, int sx, int sy, int cnt,
                              logic [3:0] act, bit chk_b, int bx, int by);
    vec_t v;
    v.rst = rst; v.fire = f; v.hit = h;
    v.sx = 10'(sx); v.sy = 10'(sy);
    v.cnt = cnt; v.act = act; v.chk_b = chk_b;
    v.bx = 10'(bx); v.by = 10'(by);
    return v;
  endfunction

  task automatic check(input string name, input int row, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0d expected=%0d", name, row, got, exp);
    end
  endtask

  // Drive one frame, queue its expectation, compare after the edge
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t g;
    Reset = v.rst; fire = v.fire; bullet_hit = v.hit;
    ship_x = v.sx; ship_y = v.sy;
    e.row = row_id; e.cnt = v.cnt; e.act = v.act;
    e.chk_b = v.chk_b; e.bx = v.bx; e.by = v.by;
    sb.push_back(e);
    @(posedge frame_clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", row_id, 0, 1);
    end else begin
      g = sb.pop_front();
      check("ammo_count", g.row, int'(ammo_count), g.cnt);
      check("ammo_active", g.row, int'(act_v), int'(g.act));
      if (g.chk_b) begin
        check("ball_ammo_x", g.row, int'(ball_ammo_x), int'(g.bx));
        check("ball_ammo_y", g.row, int'(ball_ammo_y), int'(g.by));
      end
    end
    row_id++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog row=%0d got=timeout expected=finish", row_id);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1; fire = 1'b0; bullet_hit = 1'b0;
    ship_x = 10'd100; ship_y = 10'd400; ship_size = 10'd30;

    // Single shot then upward motion
    vecs.push_back(mk(1,0,0,100,400, 0,4'b0000,1,700,0));
    vecs.push_back(mk(0,1,0,100,400, 1,4'b0001,1,113,396));
    vecs.push_back(mk(0,0,0,100,400, 1,4'b0001,1,113,390));
    vecs.push_back(mk(0,0,0,100,400, 1,4'b0001,1,113,384));

    // Three slots, round robin, hit retires slot1 only
    vecs.push_back(mk(1,0,0,100,400, 0,4'b0000,1,700,0));
    vecs.push_back(mk(0,1,0,100,400, 1,4'b0001,1,113,396));
    for (int r = 6; r <= 13; r++) vecs.push_back(mk(0,0,0,100,400, 1,4'b0001,1,113,426-6*r));
    vecs.push_back(mk(0,1,0,200,400, 2,4'b0011,1,113,342));
    for (int r = 15; r <= 22; r++) begin
      if (r % 2 == 1) vecs.push_back(mk(0,0,0,100,400, 2,4'b0011,1,213,480-6*r));
      else            vecs.push_back(mk(0,0,0,100,400, 2,4'b0011,1,113,426-6*r));
    end
    vecs.push_back(mk(0,1,0,300,400, 3,4'b0111,1,213,342));
    vecs.push_back(mk(0,0,0,100,400, 3,4'b0111,1,313,390));
    vecs.push_back(mk(0,0,0,100,400, 3,4'b0111,1,113,276));
    vecs.push_back(mk(0,0,0,100,400, 3,4'b0111,1,213,324));
    vecs.push_back(mk(0,0,0,100,400, 3,4'b0111,1,313,372));
    vecs.push_back(mk(0,0,1,100,400, 2,4'b0101,1,113,258));
    vecs.push_back(mk(0,0,0,100,400, 2,4'b0101,1,313,360));
    vecs.push_back(mk(0,0,0,100,400, 2,4'b0101,1,113,246));

    // Top-of-screen boundary and illegal spawn height
    vecs.push_back(mk(1,0,0,100,400, 0,4'b0000,1,700,0));
    vecs.push_back(mk(0,1,0,100,6,   0,4'b0000,1,700,0));
    vecs.push_back(mk(0,1,0,100,12,  1,4'b0001,1,113,8));
    vecs.push_back(mk(0,0,0,100,400, 0,4'b0000,1,700,0));
    for (int r = 0; r < 7; r++) vecs.push_back(mk(0,0,0,100,400, 0,4'b0000,1,700,0));
    vecs.push_back(mk(0,1,0,100,13,  1,4'b0001,1,113,9));
    vecs.push_back(mk(0,0,0,100,400, 1,4'b0001,1,113,3));
    vecs.push_back(mk(0,0,0,100,400, 0,4'b0000,1,700,0));

    // Hit on empty pool ignored; spawn avoids the slot being killed
    vecs.push_back(mk(1,0,0,100,400, 0,4'b0000,1,700,0));
    vecs.push_back(mk(0,0,1,100,400, 0,4'b0000,1,700,0));
    vecs.push_back(mk(0,1,0,100,400, 1,4'b0001,1,113,396));
    for (int r = 1; r <= 8; r++) vecs.push_back(mk(0,0,0,100,400, 1,4'b0001,1,113,396-6*r));
    vecs.push_back(mk(0,1,1,200,400, 1,4'b0010,1,700,0));
    vecs.push_back(mk(0,0,0,100,400, 1,4'b0010,1,213,390));

    // Reset mid-flight during cooldown, then immediate shot
    vecs.push_back(mk(1,0,0,100,400, 0,4'b0000,1,700,0));
    vecs.push_back(mk(0,1,0,100,400, 1,4'b0001,1,113,396));
    for (int r = 0; r < 8; r++) vecs.push_back(mk(0,0,0,100,400, 1,4'b0001,0,0,0));
    vecs.push_back(mk(0,1,0,200,400, 2,4'b0011,0,0,0));
    for (int r = 0; r < 8; r++) vecs.push_back(mk(0,0,0,100,400, 2,4'b0011,0,0,0));
    vecs.push_back(mk(0,1,0,300,400, 3,4'b0111,0,0,0));
    vecs.push_back(mk(0,0,0,100,400, 3,4'b0111,0,0,0));
    vecs.push_back(mk(1,0,0,100,400, 0,4'b0000,1,700,0));
    vecs.push_back(mk(0,1,0,100,400, 1,4'b0001,1,113,396));

    foreach (vecs[i]) apply(vecs[i]);

    check("ammo_X0", row_id, int'(ammo_X[0]), 113);
    check("ammo_Y0", row_id, int'(ammo_Y[0]), 396);
    check("ball_ammo_size", row_id, int'(ball_ammo_size), 4);

    // Held fire for 40 frames
    apply(mk(1,0,0,100,400, 0,4'b0000,1,700,0));
    for (int f = 0; f < 40; f++) begin
`ifdef AMMO_AUTOFIRE_EN
      n = 1 + int'(f >= 9) + int'(f >= 18) + int'(f >= 27);
`else
      n = 1;
`endif
      apply(mk(0,1,0,100,400, n,4'((1 << n) - 1),0,0,0));
    end
    // Release one frame, press again
`ifdef AMMO_AUTOFIRE_EN
    apply(mk(0,0,0,100,400, 4,4'b1111,0,0,0));
    apply(mk(0,1,0,100,400, 4,4'b1111,0,0,0));
`else
    apply(mk(0,0,0,100,400, 1,4'b0001,0,0,0));
    apply(mk(0,1,0,100,400, 2,4'b0011,0,0,0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
